// File: rtl/pwl_mc_pkg.sv
// Shared constants and helpers for the multi-channel piecewise-linear evaluator.
// Width helpers keep every stage sized so intermediate arithmetic never wraps.
package pwl_pkg;

    localparam int PWL_FLOOR         = 0;
    localparam int PWL_ROUND_HALF_UP = 1;

    function automatic int ch_bits(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

    function automatic int prod_width(input int slope_bits, input int low_bits);
        return slope_bits + low_bits + 1;
    endfunction

    function automatic int sum_width(input int off_bits, input int corr_bits);
        return ((off_bits > corr_bits) ? off_bits : corr_bits) + 1;
    endfunction

    // Clamp a sign-extended value into the signed range of an w-bit result.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/pwl_mc_if.sv
// Request/result stream between the phase generators and the accumulators.
interface pwl_mc_if #(
    parameter int N_CH          = 4,
    parameter int PWL_ADDR_BITS = 12,
    parameter int OUT_BITS      = 16
);
    localparam int CH_BITS = pwl_pkg::ch_bits(N_CH);

    logic                       in_valid;
    logic                       in_ready;
    logic [CH_BITS-1:0]         in_ch;
    logic [PWL_ADDR_BITS-1:0]   in_t;
    logic                       out_valid;
    logic                       out_ready;
    logic [CH_BITS-1:0]         out_ch;
    logic signed [OUT_BITS-1:0] out_v;
    logic                       out_sat;

    modport master (
        output in_valid, in_ch, in_t, out_ready,
        input  in_ready, out_valid, out_ch, out_v, out_sat
    );

    modport slave (
        input  in_valid, in_ch, in_t, out_ready,
        output in_ready, out_valid, out_ch, out_v, out_sat
    );
endinterface

// File: rtl/pwl_coef_ram.sv
// Single-write, synchronous read-first coefficient RAM with read enable.
module pwl_coef_ram #(
    parameter int DATA_W = 28,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/pwl_mc.sv
// Time-multiplexed N_CH-channel PWL evaluator: S0 address, S1 RAM read,
// S2 multiply/round/shift, S3 add/saturate into the output registers.
module pwl_mc
    import pwl_pkg::*;
#(
    parameter int N_CH            = 4,
    parameter int PWL_ADDR_BITS   = 12,
    parameter int PWL_LOW_BITS    = 4,
    parameter int TABLE_ADDR_BITS = 6,
    parameter int OFFSET_BITS     = 16,
    parameter int SLOPE_BITS      = 12,
    parameter int SHIFT           = 4,
    parameter int OUT_BITS        = 16,
    parameter int ROUND           = PWL_FLOOR,
    localparam int CH_BITS        = ch_bits(N_CH)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    pwl_mc_if.slave                              io,
    input  logic                                 wr_en,
    input  logic [CH_BITS-1:0]                   wr_ch,
    input  logic [TABLE_ADDR_BITS-1:0]           wr_addr,
    input  logic [OFFSET_BITS+SLOPE_BITS-1:0]    wr_data
);
    localparam int IDX_BITS = TABLE_ADDR_BITS + PWL_LOW_BITS;
    localparam int PROD_W   = prod_width(SLOPE_BITS, PWL_LOW_BITS);
    localparam int CORR_W   = PROD_W + 1;
    localparam int SUM_W    = sum_width(OFFSET_BITS, CORR_W);
    localparam int RND_SH   = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [CORR_W-1:0] RND =
        (ROUND == PWL_ROUND_HALF_UP && SHIFT > 0) ? (CORR_W'(1) << RND_SH) : '0;

    logic                             adv;
    logic                             oor;
    logic [TABLE_ADDR_BITS-1:0]       seg_raw;
    logic [PWL_LOW_BITS-1:0]          frac_raw;
    logic [OFFSET_BITS+SLOPE_BITS-1:0] ram_rdata;

    logic                             s0_valid_q, s0_valid_d;
    logic [CH_BITS-1:0]               s0_ch_q, s0_ch_d;
    logic [TABLE_ADDR_BITS-1:0]       s0_seg_q, s0_seg_d;
    logic [PWL_LOW_BITS-1:0]          s0_frac_q, s0_frac_d;
    logic                             s1_valid_q, s1_valid_d;
    logic [CH_BITS-1:0]               s1_ch_q, s1_ch_d;
    logic [PWL_LOW_BITS-1:0]          s1_frac_q, s1_frac_d;
    logic                             s2_valid_q, s2_valid_d;
    logic [CH_BITS-1:0]               s2_ch_q, s2_ch_d;
    logic signed [OFFSET_BITS-1:0]    s2_off_q, s2_off_d;
    logic signed [CORR_W-1:0]         s2_corr_q, s2_corr_d;
    logic                             out_valid_q, out_valid_d;
    logic [CH_BITS-1:0]               out_ch_q, out_ch_d;
    logic signed [OUT_BITS-1:0]       out_v_q, out_v_d;
    logic                             out_sat_q, out_sat_d;

    logic signed [SLOPE_BITS-1:0]     slope;
    logic signed [OFFSET_BITS-1:0]    offset;
    logic signed [PROD_W-1:0]         prod;
    logic signed [CORR_W-1:0]         corr;
    logic signed [SUM_W-1:0]          sum;
    logic signed [63:0]               sat_full;

    // Any set bit above the table span pins the lookup to the last point.
    if (PWL_ADDR_BITS > IDX_BITS) begin : g_wide_t
        assign oor     = |io.in_t[PWL_ADDR_BITS-1:IDX_BITS];
        assign seg_raw = io.in_t[IDX_BITS-1:PWL_LOW_BITS];
    end else begin : g_narrow_t
        assign oor     = 1'b0;
        assign seg_raw = TABLE_ADDR_BITS'(io.in_t[PWL_ADDR_BITS-1:PWL_LOW_BITS]);
    end
    assign frac_raw = io.in_t[PWL_LOW_BITS-1:0];

    assign adv         = !out_valid_q || io.out_ready;
    assign io.in_ready = adv;

    pwl_coef_ram #(
        .DATA_W (OFFSET_BITS + SLOPE_BITS),
        .ADDR_W (CH_BITS + TABLE_ADDR_BITS),
        .DEPTH  (N_CH << TABLE_ADDR_BITS)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr ({wr_ch, wr_addr}),
        .wdata (wr_data),
        .re    (adv),
        .raddr ({s0_ch_q, s0_seg_q}),
        .rdata (ram_rdata)
    );

    always_comb begin
        slope    = $signed(ram_rdata[SLOPE_BITS-1:0]);
        offset   = $signed(ram_rdata[OFFSET_BITS+SLOPE_BITS-1:SLOPE_BITS]);
        prod     = PROD_W'(slope) * PROD_W'($signed({1'b0, s1_frac_q}));
        corr     = (CORR_W'(prod) + RND) >>> SHIFT;
        sum      = SUM_W'(s2_off_q) + SUM_W'(s2_corr_q);
        sat_full = saturate(64'(sum), OUT_BITS);
    end

    always_comb begin
        s0_valid_d  = s0_valid_q;
        s0_ch_d     = s0_ch_q;
        s0_seg_d    = s0_seg_q;
        s0_frac_d   = s0_frac_q;
        s1_valid_d  = s1_valid_q;
        s1_ch_d     = s1_ch_q;
        s1_frac_d   = s1_frac_q;
        s2_valid_d  = s2_valid_q;
        s2_ch_d     = s2_ch_q;
        s2_off_d    = s2_off_q;
        s2_corr_d   = s2_corr_q;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        out_v_d     = out_v_q;
        out_sat_d   = out_sat_q;
        if (adv) begin
            s0_valid_d  = io.in_valid;
            s0_ch_d     = io.in_ch;
            s0_seg_d    = oor ? '1 : seg_raw;
            s0_frac_d   = oor ? '1 : frac_raw;
            s1_valid_d  = s0_valid_q;
            s1_ch_d     = s0_ch_q;
            s1_frac_d   = s0_frac_q;
            s2_valid_d  = s1_valid_q;
            s2_ch_d     = s1_ch_q;
            s2_off_d    = offset;
            s2_corr_d   = corr;
            out_valid_d = s2_valid_q;
            // Result registers only load on real samples so bubbles leave them untouched.
            if (s2_valid_q) begin
                out_ch_d  = s2_ch_q;
                out_v_d   = OUT_BITS'(sat_full);
                out_sat_d = (sat_full != 64'(sum));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid_q  <= 1'b0;
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_v_q     <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            s0_valid_q  <= s0_valid_d;
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_v_q     <= out_v_d;
            out_sat_q   <= out_sat_d;
        end
    end

    always_ff @(posedge clk) begin
        s0_ch_q   <= s0_ch_d;
        s0_seg_q  <= s0_seg_d;
        s0_frac_q <= s0_frac_d;
        s1_ch_q   <= s1_ch_d;
        s1_frac_q <= s1_frac_d;
        s2_ch_q   <= s2_ch_d;
        s2_off_q  <= s2_off_d;
        s2_corr_q <= s2_corr_d;
    end

    assign io.out_valid = out_valid_q;
    assign io.out_ch    = out_ch_q;
    assign io.out_v     = out_v_q;
    assign io.out_sat   = out_sat_q;
endmodule

// File: tb/tb_pwl_mc.sv
// Directed bench for pwl_mc: lookup, clamping, saturation, rounding, flow control,
// write collision and reset; a floor and a round-half-up instance share the write port.
module tb_pwl_mc;
    import pwl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [1:0]  wr_ch;
    logic [5:0]  wr_addr;
    logic [27:0] wr_data;

    always #5 clk = ~clk;

    pwl_mc_if #(.N_CH(4), .PWL_ADDR_BITS(12), .OUT_BITS(16)) io ();
    pwl_mc_if #(.N_CH(4), .PWL_ADDR_BITS(12), .OUT_BITS(16)) io_r ();

    pwl_mc #(.ROUND(PWL_FLOOR)) dut (
        .clk(clk), .rst(rst), .io(io),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    pwl_mc #(.ROUND(PWL_ROUND_HALF_UP)) dut_r (
        .clk(clk), .rst(rst), .io(io_r),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    typedef struct {
        int ch;
        int v;
        bit sat;
    } exp_t;

    int   nvec = 0;
    int   nerr = 0;
    int   tb_off   [4][64];
    int   tb_slope [4][64];
    exp_t q [$];

    task automatic wr(input int ch, input int seg, input int off, input int slope);
        wr_en   = 1'b1;
        wr_ch   = 2'(ch);
        wr_addr = 6'(seg);
        wr_data = {16'(off), 12'(slope)};
        @(negedge clk);
        wr_en = 1'b0;
        tb_off[ch][seg]   = off;
        tb_slope[ch][seg] = slope;
    endtask

    function automatic exp_t model(input int ch, input int t);
        int seg, frac, p, s;
        exp_t e;
        seg = (t >> 4) & 63;
        frac = t & 15;
        if ((t >> 10) != 0) begin
            seg = 63;
            frac = 15;
        end
        p = tb_slope[ch][seg] * frac;
        s = tb_off[ch][seg] + (p >>> 4);
        e.ch = ch;
        e.sat = 1'b0;
        if (s > 32767) begin
            s = 32767;
            e.sat = 1'b1;
        end else if (s < -32768) begin
            s = -32768;
            e.sat = 1'b1;
        end
        e.v = s;
        return e;
    endfunction

    // Issue one request on the floor instance and wait for its result.
    task automatic run_one(input int ch, input int t, output int lat);
        io.in_valid  = 1'b1;
        io.in_ch     = 2'(ch);
        io.in_t      = 12'(t);
        io.out_ready = 1'b1;
        @(negedge clk);
        io.in_valid = 1'b0;
        lat = 0;
        while (io.out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wr_en = 1'b0;
        io.in_valid = 1'b0; io.out_ready = 1'b1; io.in_ch = '0; io.in_t = '0;
        io_r.in_valid = 1'b0; io_r.out_ready = 1'b1; io_r.in_ch = '0; io_r.in_t = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        nvec++; if (io.out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid got %b want 0", io.out_valid); end
        nvec++; if (io.out_v !== 16'd0) begin nerr++; $display("FAIL reset_out_v got %0d want 0", io.out_v); end
        nvec++; if (io.out_ch !== 2'd0) begin nerr++; $display("FAIL reset_out_ch got %0d want 0", io.out_ch); end
        nvec++; if (io.out_sat !== 1'b0) begin nerr++; $display("FAIL reset_out_sat got %b want 0", io.out_sat); end
        nvec++; if (io.in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready got %b want 1", io.in_ready); end
    endtask

    task automatic test_basic();
        int lat;
        wr(1, 5, 100, 32);
        run_one(1, 88, lat);
        nvec++; if (lat !== 3) begin nerr++; $display("FAIL basic_latency got %0d want 3", lat); end
        nvec++; if ($signed(io.out_v) !== 16'sd116) begin nerr++; $display("FAIL basic_out_v got %0d want 116", $signed(io.out_v)); end
        nvec++; if (io.out_ch !== 2'd1) begin nerr++; $display("FAIL basic_out_ch got %0d want 1", io.out_ch); end
        nvec++; if (io.out_sat !== 1'b0) begin nerr++; $display("FAIL basic_out_sat got %b want 0", io.out_sat); end
    endtask

    task automatic test_clamp();
        int lat;
        wr(0, 63, 1000, -16);
        run_one(0, 'h400, lat);
        nvec++; if (lat !== 3 || $signed(io.out_v) !== 16'sd985) begin nerr++; $display("FAIL clamp_400 got %0d lat %0d want 985 lat 3", $signed(io.out_v), lat); end
        run_one(0, 'hFFF, lat);
        nvec++; if ($signed(io.out_v) !== 16'sd985 || io.out_sat !== 1'b0) begin nerr++; $display("FAIL clamp_fff got %0d sat %b want 985 sat 0", $signed(io.out_v), io.out_sat); end
        run_one(0, 1012, lat);
        nvec++; if ($signed(io.out_v) !== 16'sd996) begin nerr++; $display("FAIL in_range_seg63 got %0d want 996", $signed(io.out_v)); end
    endtask

    task automatic test_saturate();
        int lat;
        wr(0, 0, 32760, 2047);
        run_one(0, 15, lat);
        nvec++; if ($signed(io.out_v) !== 16'sd32767 || io.out_sat !== 1'b1) begin nerr++; $display("FAIL sat_pos got %0d sat %b want 32767 sat 1", $signed(io.out_v), io.out_sat); end
        wr(0, 0, -32760, -2048);
        run_one(0, 15, lat);
        nvec++; if ($signed(io.out_v) !== -16'sd32768 || io.out_sat !== 1'b1) begin nerr++; $display("FAIL sat_neg got %0d sat %b want -32768 sat 1", $signed(io.out_v), io.out_sat); end
        run_one(0, 0, lat);
        nvec++; if ($signed(io.out_v) !== -16'sd32760 || io.out_sat !== 1'b0) begin nerr++; $display("FAIL sat_edge got %0d sat %b want -32760 sat 0", $signed(io.out_v), io.out_sat); end
    endtask

    task automatic test_round();
        int lat;
        int tv [2] = '{152, 168};
        int wf [2] = '{0, -1};
        int wr_ [2] = '{1, 0};
        wr(2, 9, 0, 1);
        wr(2, 10, 0, -1);
        for (int i = 0; i < 2; i++) begin
            io.in_valid = 1'b1; io.in_ch = 2'd2; io.in_t = 12'(tv[i]); io.out_ready = 1'b1;
            io_r.in_valid = 1'b1; io_r.in_ch = 2'd2; io_r.in_t = 12'(tv[i]); io_r.out_ready = 1'b1;
            @(negedge clk);
            io.in_valid = 1'b0;
            io_r.in_valid = 1'b0;
            lat = 0;
            while (io_r.out_valid !== 1'b1 && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            nvec++; if (io.out_v !== 16'(wf[i])) begin nerr++; $display("FAIL round_floor_%0d got %0d want %0d", i, $signed(io.out_v), wf[i]); end
            nvec++; if (lat !== 3 || io_r.out_v !== 16'(wr_[i])) begin nerr++; $display("FAIL round_half_up_%0d got %0d lat %0d want %0d lat 3", i, $signed(io_r.out_v), lat, wr_[i]); end
        end
    endtask

    task automatic fill_table();
        for (int c = 0; c < 4; c++)
            for (int s = 0; s < 64; s++)
                wr(c, s, int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 4095)) - 2048);
    endtask

    task automatic test_backpressure();
        int reqc [6] = '{0, 1, 2, 3, 1, 2};
        int reqt [6] = '{88, 1024, 15, 500, 1100, 7};
        int acc = 0, got = 0, cyc = 0, extra = 0;
        exp_t e;
        q.delete();
        io.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            io.in_valid = (acc < 6);
            io.in_ch = 2'(reqc[acc % 6]);
            io.in_t = 12'(reqt[acc % 6]);
            #1;
            if (io.in_valid && io.in_ready) begin
                q.push_back(model(reqc[acc], reqt[acc]));
                acc++;
            end
        end
        nvec++; if (acc !== 4 || io.in_ready !== 1'b0) begin nerr++; $display("FAIL bp_fill accepted %0d in_ready %b want 4 and 0", acc, io.in_ready); end
        while (got < 6 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            io.out_ready = 1'b1;
            io.in_valid = (acc < 6);
            io.in_ch = 2'(reqc[acc % 6]);
            io.in_t = 12'(reqt[acc % 6]);
            #1;
            if (io.out_valid && io.out_ready) begin
                nvec++;
                if (q.size() == 0) begin
                    nerr++; $display("FAIL bp_dup got ch %0d v %0d want nothing", io.out_ch, $signed(io.out_v));
                end else begin
                    e = q.pop_front();
                    if (io.out_ch !== 2'(e.ch) || io.out_v !== 16'(e.v) || io.out_sat !== e.sat) begin
                        nerr++; $display("FAIL bp_result%0d got ch %0d v %0d sat %b want ch %0d v %0d sat %b", got, io.out_ch, $signed(io.out_v), io.out_sat, e.ch, e.v, e.sat);
                    end
                end
                got++;
            end
            if (io.in_valid && io.in_ready) begin
                q.push_back(model(reqc[acc], reqt[acc]));
                acc++;
            end
        end
        io.in_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (io.out_valid) extra++;
        end
        nvec++; if (got !== 6 || extra !== 0 || q.size() !== 0) begin nerr++; $display("FAIL bp_count got %0d extra %0d left %0d want 6 0 0", got, extra, q.size()); end
    endtask

    task automatic test_random();
        int sent = 0, got = 0, cyc = 0, bad = 0;
        int c, t;
        exp_t e;
        q.delete();
        while (got < 1000 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            c = int'($urandom_range(0, 3));
            t = int'($urandom_range(0, 1279));
            io.out_ready = ($urandom_range(0, 3) != 0);
            io.in_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
            io.in_ch = 2'(c);
            io.in_t = 12'(t);
            #1;
            if (io.out_valid && io.out_ready) begin
                nvec++;
                if (q.size() == 0) begin
                    nerr++; bad++; $display("FAIL rand_dup got v %0d want nothing", $signed(io.out_v));
                end else begin
                    e = q.pop_front();
                    if (io.out_ch !== 2'(e.ch) || io.out_v !== 16'(e.v) || io.out_sat !== e.sat) begin
                        nerr++; bad++;
                        if (bad < 10) $display("FAIL rand_result%0d got ch %0d v %0d sat %b want ch %0d v %0d sat %b", got, io.out_ch, $signed(io.out_v), io.out_sat, e.ch, e.v, e.sat);
                    end
                end
                got++;
            end
            if (io.in_valid && io.in_ready) begin
                q.push_back(model(c, t));
                sent++;
            end
        end
        io.in_valid = 1'b0;
        io.out_ready = 1'b1;
        nvec++; if (got !== 1000 || q.size() !== 0) begin nerr++; $display("FAIL rand_count got %0d left %0d want 1000 0", got, q.size()); end
    endtask

    task automatic test_collision();
        int lat;
        wr(3, 7, 200, 16);
        io.out_ready = 1'b1;
        io.in_valid = 1'b1; io.in_ch = 2'd3; io.in_t = 12'd116;
        @(negedge clk);
        io.in_valid = 1'b0;
        wr_en = 1'b1; wr_ch = 2'd3; wr_addr = 6'd7; wr_data = {16'd500, 12'd32};
        @(negedge clk);
        wr_en = 1'b0;
        tb_off[3][7] = 500;
        tb_slope[3][7] = 32;
        lat = 1;
        while (io.out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        nvec++; if (lat !== 3 || $signed(io.out_v) !== 16'sd204) begin nerr++; $display("FAIL collision_old got %0d lat %0d want 204 lat 3", $signed(io.out_v), lat); end
        run_one(3, 116, lat);
        nvec++; if ($signed(io.out_v) !== 16'sd508) begin nerr++; $display("FAIL collision_new got %0d want 508", $signed(io.out_v)); end
    endtask

    task automatic test_reset_inflight();
        int seen = 0;
        io.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            io.in_valid = 1'b1; io.in_ch = 2'(i + 1); io.in_t = 12'(i * 16 + 3);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        io.in_valid = 1'b0;
        repeat (6) begin
            #1;
            if (io.out_valid) seen++;
            @(negedge clk);
        end
        #1;
        nvec++; if (seen !== 0) begin nerr++; $display("FAIL rst_inflight_valid got %0d results want 0", seen); end
        nvec++; if (io.out_v !== 16'd0 || io.out_ch !== 2'd0 || io.out_sat !== 1'b0) begin nerr++; $display("FAIL rst_inflight_outputs got v %0d ch %0d sat %b want 0 0 0", $signed(io.out_v), io.out_ch, io.out_sat); end
        nvec++; if (io.in_ready !== 1'b1) begin nerr++; $display("FAIL rst_inflight_in_ready got %b want 1", io.in_ready); end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_saturate();
        test_round();
        fill_table();
        test_backpressure();
        test_random();
        test_collision();
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
